// File: rtl/bb_decim_filter.sv
// Boxcar (TAPS) low-pass + DECIM decimator on the I/Q rails; result registers on the accepting edge (1 clk latency).
// Never backpressures: every demod_rdy strobe not overridden by reset/sync_clr is consumed.
module bb_decim_filter #(
    parameter int DATA_W    = 9,
    parameter int LOG2_TAPS = 3,
    parameter int DECIM     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sync_clr,
    input  logic signed [DATA_W-1:0] I_BB,
    input  logic signed [DATA_W-1:0] Q_BB,
    input  logic                     demod_rdy,
    output logic signed [DATA_W-1:0] I_filt,
    output logic signed [DATA_W-1:0] Q_filt,
    output logic                     filt_rdy
);

    localparam int TAPS = 1 << LOG2_TAPS;
    localparam int SW   = DATA_W + LOG2_TAPS;
    localparam int DW   = (DECIM > 1) ? $clog2(DECIM) : 1;

    typedef enum logic {FILL, RUN} state_t;

    state_t state, state_nxt;

    logic clr, accept, emit;
    logic [LOG2_TAPS-1:0] wr_ptr, fill_cnt;
    logic [DW-1:0] decim_cnt;

    logic signed [DATA_W-1:0] i_buf [TAPS];
    logic signed [DATA_W-1:0] q_buf [TAPS];
    logic signed [SW-1:0] i_sum, q_sum, i_sum_next, q_sum_next, i_rnd, q_rnd;

    assign clr    = reset | sync_clr;
    assign accept = demod_rdy & ~clr;

    // Window update: add newest sample, drop the one it overwrites.
    assign i_sum_next = i_sum + SW'(I_BB) - SW'(i_buf[wr_ptr]);
    assign q_sum_next = q_sum + SW'(Q_BB) - SW'(q_buf[wr_ptr]);
    assign i_rnd      = i_sum_next + SW'(TAPS / 2);
    assign q_rnd      = q_sum_next + SW'(TAPS / 2);

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept && state == FILL && fill_cnt == LOG2_TAPS'(TAPS - 1)) begin
            state_nxt = RUN;
        end
    end

    always_comb begin
        emit = 1'b0;
        if (accept) begin
            case (state)
                FILL:    emit = (fill_cnt == LOG2_TAPS'(TAPS - 1));
                RUN:     emit = (decim_cnt == DW'(DECIM - 1));
                default: emit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            i_sum     <= '0;
            q_sum     <= '0;
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            decim_cnt <= '0;
            I_filt    <= '0;
            Q_filt    <= '0;
            filt_rdy  <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                i_buf[k] <= '0;
                q_buf[k] <= '0;
            end
        end else begin
            filt_rdy <= emit;
            if (accept) begin
                i_sum         <= i_sum_next;
                q_sum         <= q_sum_next;
                i_buf[wr_ptr] <= I_BB;
                q_buf[wr_ptr] <= Q_BB;
                wr_ptr        <= wr_ptr + 1'b1;
                if (state == FILL) begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
                if (emit) begin
                    decim_cnt <= '0;
                end else if (state == RUN) begin
                    decim_cnt <= decim_cnt + 1'b1;
                end
            end
            if (emit) begin
                I_filt <= DATA_W'(i_rnd >>> LOG2_TAPS);
                Q_filt <= DATA_W'(q_rnd >>> LOG2_TAPS);
            end
        end
    end

endmodule
